// File: rtl/useq_pkg.sv
// Shared definitions for the microsequencer: COND field codes, sequencer states
// and bit positions of the {N, Z, V, C} flags.
package useq_pkg;

    localparam int unsigned CondNext   = 0;
    localparam int unsigned CondBn     = 1;
    localparam int unsigned CondBz     = 2;
    localparam int unsigned CondBv     = 3;
    localparam int unsigned CondBc     = 4;
    localparam int unsigned CondBir13  = 5;
    localparam int unsigned CondJump   = 6;
    localparam int unsigned CondDecode = 7;
    localparam int unsigned CondCall   = 8;
    localparam int unsigned CondRet    = 9;
    localparam int unsigned CondWait   = 10;

    typedef enum logic [1:0] {
        StRun,
        StStall,
        StFault
    } useq_state_e;

    localparam int unsigned FlagN = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagV = 1;
    localparam int unsigned FlagC = 0;

endpackage

// File: rtl/useq_return_stack.sv
// LIFO of microsubroutine return addresses. Requests against a full or empty
// stack are ignored here; the parent turns them into a fault.
module useq_return_stack #(
    parameter int unsigned Width = 11,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [Width-1:0]         data_i,
    output logic [Width-1:0]         top_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int unsigned AddrW  = $clog2(Depth);
    localparam int unsigned LevelW = AddrW + 1;

    logic [Width-1:0]  mem_q [Depth];
    logic [LevelW-1:0] level_q;
    logic [LevelW-1:0] top_idx;

    assign top_idx = level_q - 1'b1;
    assign top_o   = mem_q[top_idx[AddrW-1:0]];
    assign full_o  = (level_q == LevelW'(Depth));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !full_o) begin
            mem_q[level_q[AddrW-1:0]] <= data_i;
            level_q                   <= level_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            level_q <= level_q - 1'b1;
        end
    end

endmodule

// File: rtl/useq_microsequencer.sv
// Control-store address sequencer with return stack, memory wait stalls,
// trap entry at DECODE and a sticky fault state left only through reset.
module useq_microsequencer
    import useq_pkg::*;
#(
    parameter int unsigned DATAWIDTH_CSADDR   = 11,
    parameter int unsigned DATAWIDTH_OP       = 8,
    parameter int unsigned DATAWIDTH_COND_MIR = 4,
    parameter int unsigned STACK_DEPTH        = 4,
    parameter int unsigned RESET_VECTOR       = 0,
    parameter int unsigned TRAP_VECTOR        = 'h7F0,
    parameter int unsigned FAULT_VECTOR       = 'h7FF
) (
    input  logic                          uSequencer_CLOCK_50,
    input  logic                          uSequencer_Reset_InLow,
    input  logic [DATAWIDTH_COND_MIR-1:0] uSequencer_Cond_In,
    input  logic [DATAWIDTH_CSADDR-1:0]   uSequencer_JumpAddr_In,
    input  logic [DATAWIDTH_OP-1:0]       uSequencer_Op_In,
    input  logic                          uSequencer_IR13_In,
    input  logic [3:0]                    uSequencer_Flags_InLow,
    input  logic                          uSequencer_MemReady_In,
    input  logic                          uSequencer_Trap_In,
    output logic [DATAWIDTH_CSADDR-1:0]   uSequencer_CSAddr_Out,
    output logic                          uSequencer_Stall_Out,
    output logic                          uSequencer_TrapAck_Out,
    output logic                          uSequencer_Fault_Out,
    output logic [$clog2(STACK_DEPTH):0]  uSequencer_StackLevel_Out
);

    localparam int unsigned AW   = DATAWIDTH_CSADDR;
    localparam int unsigned PadW = DATAWIDTH_CSADDR - DATAWIDTH_OP - 1;
    localparam logic [AW-1:0] ResetVec = AW'(RESET_VECTOR);
    localparam logic [AW-1:0] TrapVec  = AW'(TRAP_VECTOR);
    localparam logic [AW-1:0] FaultVec = AW'(FAULT_VECTOR);

    useq_state_e   state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          stall_q, stall_d;
    logic          ack_q, ack_d;
    logic          fault_q, fault_d;

    logic [AW-1:0] addr_inc;
    logic [AW-1:0] dispatch;
    logic [3:0]    flag_true;
    int unsigned   cond_val;
    logic          push, pop;
    logic [AW-1:0] stk_top;
    logic          stk_full, stk_empty;

    assign addr_inc  = addr_q + 1'b1;
    assign dispatch  = {1'b1, uSequencer_Op_In, {PadW{1'b0}}};
    assign flag_true = ~uSequencer_Flags_InLow;
    assign cond_val  = 32'(uSequencer_Cond_In);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        stall_d = 1'b0;
        ack_d   = 1'b0;
        fault_d = fault_q;
        push    = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            StRun: begin
                addr_d = addr_inc;
                case (cond_val)
                    CondBn:    if (flag_true[FlagN]) addr_d = uSequencer_JumpAddr_In;
                    CondBz:    if (flag_true[FlagZ]) addr_d = uSequencer_JumpAddr_In;
                    CondBv:    if (flag_true[FlagV]) addr_d = uSequencer_JumpAddr_In;
                    CondBc:    if (flag_true[FlagC]) addr_d = uSequencer_JumpAddr_In;
                    CondBir13: if (uSequencer_IR13_In) addr_d = uSequencer_JumpAddr_In;
                    CondJump:  addr_d = uSequencer_JumpAddr_In;
                    CondDecode: begin
                        if (uSequencer_Trap_In) begin
                            addr_d = TrapVec;
                            ack_d  = 1'b1;
                        end else begin
                            addr_d = dispatch;
                        end
                    end
                    CondCall: begin
                        if (stk_full) begin
                            state_d = StFault;
                            addr_d  = FaultVec;
                            fault_d = 1'b1;
                        end else begin
                            push   = 1'b1;
                            addr_d = uSequencer_JumpAddr_In;
                        end
                    end
                    CondRet: begin
                        if (stk_empty) begin
                            state_d = StFault;
                            addr_d  = FaultVec;
                            fault_d = 1'b1;
                        end else begin
                            pop    = 1'b1;
                            addr_d = stk_top;
                        end
                    end
                    CondWait: begin
                        if (!uSequencer_MemReady_In) begin
                            state_d = StStall;
                            addr_d  = addr_q;
                            stall_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            StStall: begin
                if (uSequencer_MemReady_In) begin
                    state_d = StRun;
                    addr_d  = addr_inc;
                end else begin
                    stall_d = 1'b1;
                end
            end
            StFault: begin
                addr_d  = FaultVec;
                fault_d = 1'b1;
            end
            default: state_d = StFault;
        endcase
    end

    always_ff @(posedge uSequencer_CLOCK_50 or negedge uSequencer_Reset_InLow) begin
        if (!uSequencer_Reset_InLow) begin
            state_q <= StRun;
            addr_q  <= ResetVec;
            stall_q <= 1'b0;
            ack_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            stall_q <= stall_d;
            ack_q   <= ack_d;
            fault_q <= fault_d;
        end
    end

    useq_return_stack #(
        .Width (AW),
        .Depth (STACK_DEPTH)
    ) u_stack (
        .clk_i   (uSequencer_CLOCK_50),
        .rst_ni  (uSequencer_Reset_InLow),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (addr_inc),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty),
        .level_o (uSequencer_StackLevel_Out)
    );

    assign uSequencer_CSAddr_Out  = addr_q;
    assign uSequencer_Stall_Out   = stall_q;
    assign uSequencer_TrapAck_Out = ack_q;
    assign uSequencer_Fault_Out   = fault_q;

endmodule

// File: tb/tb_useq_microsequencer.sv
// Randomised bench for useq_microsequencer: a reference model pushes expected
// outputs into a queue and a negedge monitor pops and compares them.
module tb_useq_microsequencer;

    localparam int AMOD = 2048;
    localparam int TV   = 'h7F0;
    localparam int FV   = 'h7FF;
    localparam int DEP  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  cond = '0;
    logic [10:0] jump = '0;
    logic [7:0]  op = '0;
    logic        ir13 = 1'b0;
    logic [3:0]  flags = 4'hF;
    logic        mem = 1'b1;
    logic        trap = 1'b0;
    logic [10:0] csaddr;
    logic        stall, ack, fault;
    logic [2:0]  level;

    always #5 clk = ~clk;

    useq_microsequencer dut (
        .uSequencer_CLOCK_50       (clk),
        .uSequencer_Reset_InLow    (rst_n),
        .uSequencer_Cond_In        (cond),
        .uSequencer_JumpAddr_In    (jump),
        .uSequencer_Op_In          (op),
        .uSequencer_IR13_In        (ir13),
        .uSequencer_Flags_InLow    (flags),
        .uSequencer_MemReady_In    (mem),
        .uSequencer_Trap_In        (trap),
        .uSequencer_CSAddr_Out     (csaddr),
        .uSequencer_Stall_Out      (stall),
        .uSequencer_TrapAck_Out    (ack),
        .uSequencer_Fault_Out      (fault),
        .uSequencer_StackLevel_Out (level)
    );

    typedef struct {
        int addr;
        bit stall;
        bit ack;
        bit fault;
        int level;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: 0 = running, 1 = waiting on memory, 2 = faulted.
    int m_addr = 0;
    int m_state = 0;
    int stk[$];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("csaddr", int'(csaddr), e.addr);
            check("stall", int'(stall), int'(e.stall));
            check("trapack", int'(ack), int'(e.ack));
            check("fault", int'(fault), int'(e.fault));
            check("level", int'(level), e.level);
        end
    end

    // Called at negedge+1; drives one cycle of inputs and returns at the next negedge+1.
    task automatic step(input int c, input int j, input int o, input bit b13, input int f,
                        input bit mr, input bit tr);
        exp_t e;
        int   nxt;
        cond  = 4'(c);
        jump  = 11'(j);
        op    = 8'(o);
        ir13  = b13;
        flags = 4'(f);
        mem   = mr;
        trap  = tr;
        e.ack = 1'b0;
        if (m_state == 2) begin
            nxt = FV;
        end else if (m_state == 1) begin
            if (mr) begin
                nxt = (m_addr + 1) % AMOD;
                m_state = 0;
            end else begin
                nxt = m_addr;
            end
        end else begin
            nxt = (m_addr + 1) % AMOD;
            if (c >= 1 && c <= 4) begin
                if (((f >> (4 - c)) & 1) == 0) nxt = j;
            end else if (c == 5) begin
                if (b13) nxt = j;
            end else if (c == 6) begin
                nxt = j;
            end else if (c == 7) begin
                if (tr) begin
                    nxt = TV;
                    e.ack = 1'b1;
                end else begin
                    nxt = 1024 + o * 4;
                end
            end else if (c == 8) begin
                if (stk.size() == DEP) begin
                    m_state = 2;
                    nxt = FV;
                end else begin
                    stk.push_back(nxt);
                    nxt = j;
                end
            end else if (c == 9) begin
                if (stk.size() == 0) begin
                    m_state = 2;
                    nxt = FV;
                end else begin
                    nxt = stk.pop_back();
                end
            end else if (c == 10) begin
                if (!mr) begin
                    nxt = m_addr;
                    m_state = 1;
                end
            end
        end
        m_addr  = nxt;
        e.addr  = nxt;
        e.stall = (m_state == 1);
        e.fault = (m_state == 2);
        e.level = stk.size();
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_csaddr", int'(csaddr), 0);
        check("rst_stall", int'(stall), 0);
        check("rst_trapack", int'(ack), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_level", int'(level), 0);
        m_addr  = 0;
        m_state = 0;
        stk.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic simple(input int c, input int j);
        step(c, j, 0, 1'b0, 'hF, 1'b1, 1'b0);
    endtask

    initial begin
        int fault_cycles;
        @(negedge clk);
        #1;
        do_reset();

        // Count from reset, then reset mid-run at address 2.
        simple(0, 0);
        simple(0, 0);
        do_reset();

        // BZ taken and not taken from address 5.
        simple(6, 5);
        step(2, 'h40, 0, 1'b0, 'b1011, 1'b1, 1'b0);
        simple(6, 5);
        step(2, 'h40, 0, 1'b0, 'b1111, 1'b1, 1'b0);

        // DECODE dispatch and trap entry.
        step(7, 0, 'h80, 1'b0, 'hF, 1'b1, 1'b0);
        step(7, 0, 'h80, 1'b0, 'hF, 1'b1, 1'b1);
        simple(0, 0);

        // Three stalled cycles at 0x10, then release.
        simple(6, 'h10);
        step(10, 0, 0, 1'b0, 'hF, 1'b0, 1'b0);
        step(0, 0, 0, 1'b0, 'hF, 1'b0, 1'b0);
        step(6, 'h55, 0, 1'b0, 'hF, 1'b0, 1'b0);
        step(6, 'h55, 0, 1'b0, 'hF, 1'b1, 1'b0);

        // Nested call/return.
        simple(6, 'h20);
        simple(8, 'h100);
        simple(0, 0);
        simple(8, 'h200);
        simple(9, 0);
        simple(9, 0);

        // Overflow on the fifth CALL, held until reset.
        for (int i = 0; i < 5; i++) simple(8, 'h300 + i);
        simple(0, 0);
        simple(6, 'h10);
        do_reset();

        // Underflow.
        simple(9, 0);
        simple(0, 0);
        do_reset();

        // Randomised traffic.
        fault_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 15), $urandom_range(0, AMOD - 1), $urandom_range(0, 255),
                 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
            if (m_state == 2) fault_cycles++;
            if (fault_cycles > 2 || $urandom_range(0, 199) == 0) begin
                fault_cycles = 0;
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
